// File: rtl/clk_gate_ctrl.sv
// Enable controller for one ICG: wakes the gated domain on request and
// acks once it is stable. After an idle period it gates the clock off again.
module clk_gate_ctrl #(
   parameter int NUM_REQ     = 4,
   parameter int WAKE_CYCLES = 2,
   parameter int IDLE_CYCLES = 8
) (
   input  logic               CLK,
   input  logic               RST,
   input  logic [NUM_REQ-1:0] req,
   input  logic [NUM_REQ-1:0] busy,
   input  logic               test_en,
   output logic               gate_en,
   output logic [NUM_REQ-1:0] ack,
   output logic               clk_active
);

   typedef enum logic [1:0] {
      S_OFF,
      S_WAKE,
      S_ON,
      S_IDLE_WAIT
   } state_t;

   localparam logic [3:0] WakeInit = 4'(WAKE_CYCLES - 1);
   localparam logic [7:0] IdleInit = 8'(IDLE_CYCLES - 1);

   state_t             state_q, state_d;
   logic               en_q, en_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic               act_q, act_d;
   logic [3:0]         wake_cnt_q, wake_cnt_d;
   logic [7:0]         idle_cnt_q, idle_cnt_d;
   logic               any_req;
   logic               any_busy;

   assign any_req  = |req;
   assign any_busy = |busy;

   always_comb begin
      state_d    = state_q;
      en_d       = en_q;
      wake_cnt_d = wake_cnt_q;
      idle_cnt_d = idle_cnt_q;
      unique case (state_q)
         S_OFF: begin
            en_d = 1'b0;
            if (any_req) begin
               state_d    = S_WAKE;
               en_d       = 1'b1;
               wake_cnt_d = WakeInit;
            end
         end
         S_WAKE: begin
            en_d = 1'b1;
            if (wake_cnt_q == 4'd0) begin
               state_d = S_ON;
            end else begin
               wake_cnt_d = wake_cnt_q - 4'd1;
            end
         end
         S_ON: begin
            en_d = 1'b1;
            if (!any_req && !any_busy) begin
               state_d    = S_IDLE_WAIT;
               idle_cnt_d = IdleInit;
            end
         end
         S_IDLE_WAIT: begin
            en_d = 1'b1;
            // A request in the final idle cycle keeps the clock running.
            if (any_req || any_busy) begin
               state_d = S_ON;
            end else if (idle_cnt_q == 8'd0) begin
               state_d = S_OFF;
               en_d    = 1'b0;
            end else begin
               idle_cnt_d = idle_cnt_q - 8'd1;
            end
         end
         default: begin
            state_d = S_OFF;
            en_d    = 1'b0;
         end
      endcase
      ack_d = (state_d == S_ON) ? req : '0;
      act_d = (state_d != S_OFF);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= S_OFF;
         en_q       <= 1'b0;
         ack_q      <= '0;
         act_q      <= 1'b0;
         wake_cnt_q <= 4'd0;
         idle_cnt_q <= 8'd0;
      end else begin
         state_q    <= state_d;
         en_q       <= en_d;
         ack_q      <= ack_d;
         act_q      <= act_d;
         wake_cnt_q <= wake_cnt_d;
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign gate_en    = en_q | test_en;
   assign ack        = ack_q;
   assign clk_active = act_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Directed bench for clk_gate_ctrl: deadline-based reference model checked
// every cycle, plus literal expectations taken from the timing rules.
module tb_clk_gate_ctrl;

   localparam int NR = 4;
   localparam int WC = 2;
   localparam int IC = 8;

   logic          CLK = 1'b0;
   logic          RST;
   logic [NR-1:0] req;
   logic [NR-1:0] busy;
   logic          test_en;
   logic          gate_en;
   logic [NR-1:0] ack;
   logic          clk_active;

   int checks   = 0;
   int failures = 0;

   clk_gate_ctrl #(
      .NUM_REQ    (NR),
      .WAKE_CYCLES(WC),
      .IDLE_CYCLES(IC)
   ) dut (
      .CLK       (CLK),
      .RST       (RST),
      .req       (req),
      .busy      (busy),
      .test_en   (test_en),
      .gate_en   (gate_en),
      .ack       (ack),
      .clk_active(clk_active)
   );

   always #5 CLK = ~CLK;

   // Model: the domain is off, waking until a ready edge, or up until
   // IC edges have passed with no activity after the last active edge.
   localparam int M_OFF  = 0;
   localparam int M_WAKE = 1;
   localparam int M_UP   = 2;

   int            m_mode;
   int            m_edge;
   int            m_ready;
   int            m_last;
   logic [NR-1:0] m_ack;

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         m_mode <= M_OFF;
         m_ack  <= '0;
         m_edge <= 0;
      end else begin
         m_edge <= m_edge + 1;
         m_ack  <= '0;
         if (m_mode == M_OFF) begin
            if (|req) begin
               m_mode  <= M_WAKE;
               m_ready <= m_edge + WC;
            end
         end else if (m_mode == M_WAKE) begin
            if (m_edge == m_ready) begin
               m_mode <= M_UP;
               m_last <= m_edge;
               m_ack  <= req;
            end
         end else begin
            if (|req || |busy) begin
               m_last <= m_edge;
               m_ack  <= req;
            end else if (m_edge >= m_last + 1 + IC) begin
               m_mode <= M_OFF;
            end
         end
      end
   end

   always @(negedge CLK) begin
      checks = checks + 1;
      if (gate_en !== ((m_mode != M_OFF) | test_en)) begin
         failures = failures + 1;
         $display("FAIL model_gate_en t=%0t got=%b exp=%b", $time, gate_en,
                  (m_mode != M_OFF) | test_en);
      end
      checks = checks + 1;
      if (clk_active !== (m_mode != M_OFF)) begin
         failures = failures + 1;
         $display("FAIL model_clk_active t=%0t got=%b exp=%b", $time,
                  clk_active, m_mode != M_OFF);
      end
      checks = checks + 1;
      if (ack !== m_ack) begin
         failures = failures + 1;
         $display("FAIL model_ack t=%0t got=%b exp=%b", $time, ack, m_ack);
      end
   end

   task automatic chk(input string name, input logic [7:0] got,
                      input logic [7:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge CLK);
      #1;
   endtask

   initial begin
      RST     = 1'b0;
      req     = '0;
      busy    = '0;
      test_en = 1'b0;
      #1;
      chk("rst_gate", 8'(gate_en), 8'h0);
      chk("rst_ack", 8'(ack), 8'h0);
      chk("rst_act", 8'(clk_active), 8'h0);
      test_en = 1'b1;
      #1;
      chk("rst_test_gate", 8'(gate_en), 8'h1);
      test_en = 1'b0;
      tick(2);
      RST = 1'b1;
      tick(2);

      busy = 4'b0010;
      tick(3);
      chk("busy_nowake_gate", 8'(gate_en), 8'h0);
      chk("busy_nowake_act", 8'(clk_active), 8'h0);
      busy = '0;

      req = 4'b0001;
      tick(1);
      chk("wake_gate", 8'(gate_en), 8'h1);
      chk("wake_act", 8'(clk_active), 8'h1);
      chk("wake_ack0", 8'(ack), 8'h0);
      tick(1);
      chk("wake_ack1", 8'(ack), 8'h0);
      tick(1);
      chk("wake_ack2", 8'(ack), 8'h1);
      req = 4'b0011;
      tick(1);
      chk("on_join_ack", 8'(ack), 8'h3);
      req = 4'b0001;
      tick(1);
      chk("on_drop_ack", 8'(ack), 8'h1);

      req = '0;
      tick(1);
      chk("drop_ack", 8'(ack), 8'h0);
      tick(7);
      chk("idle_last_gate", 8'(gate_en), 8'h1);
      tick(1);
      chk("off_gate", 8'(gate_en), 8'h0);
      chk("off_act", 8'(clk_active), 8'h0);

      req = 4'b0001;
      tick(3);
      chk("rewake_ack", 8'(ack), 8'h1);
      req = '0;
      tick(5);
      req = 4'b0100;
      tick(1);
      chk("idle3_req_ack", 8'(ack), 8'h4);
      chk("idle3_req_gate", 8'(gate_en), 8'h1);

      req = '0;
      tick(8);
      req = 4'b1000;
      tick(1);
      chk("idle0_req_gate", 8'(gate_en), 8'h1);
      chk("idle0_req_ack", 8'(ack), 8'h8);

      req  = '0;
      busy = 4'b0010;
      tick(5);
      chk("busy_ack", 8'(ack), 8'h0);
      chk("busy_gate", 8'(gate_en), 8'h1);
      busy = '0;
      tick(8);
      chk("busy_idle_gate", 8'(gate_en), 8'h1);
      tick(1);
      chk("busy_off_gate", 8'(gate_en), 8'h0);

      test_en = 1'b1;
      #1;
      chk("test_gate", 8'(gate_en), 8'h1);
      chk("test_act", 8'(clk_active), 8'h0);
      chk("test_ack", 8'(ack), 8'h0);
      test_en = 1'b0;
      #1;
      chk("test_off_gate", 8'(gate_en), 8'h0);

      req = 4'b0001;
      tick(1);
      chk("pre_rst_gate", 8'(gate_en), 8'h1);
      #2;
      RST = 1'b0;
      #1;
      chk("mid_rst_gate", 8'(gate_en), 8'h0);
      chk("mid_rst_ack", 8'(ack), 8'h0);
      chk("mid_rst_act", 8'(clk_active), 8'h0);
      tick(2);
      RST = 1'b1;
      tick(1);
      chk("rst_rewake_gate", 8'(gate_en), 8'h1);
      chk("rst_rewake_ack0", 8'(ack), 8'h0);
      tick(1);
      chk("rst_rewake_ack1", 8'(ack), 8'h0);
      tick(1);
      chk("rst_rewake_ack2", 8'(ack), 8'h1);

      test_en = 1'b1;
      req     = 4'b1111;
      tick(1);
      chk("all_req_ack", 8'(ack), 8'hf);
      req = '0;
      tick(12);
      chk("test_hold_gate", 8'(gate_en), 8'h1);
      chk("test_hold_act", 8'(clk_active), 8'h0);
      test_en = 1'b0;
      #1;
      chk("test_rel_gate", 8'(gate_en), 8'h0);
      tick(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
